// File: rtl/cpu_bus_responder_if.sv
// CPU execute-stage memory bus, responder side.
// master: CPU execute FSM; slave: cpu_bus_responder.
interface cpu_bus_responder_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic        cpu_stall;

  modport master (
    output cpu_addr, cpu_data_out, cpu_write_en, cpu_read_en,
    input  cpu_data_in, cpu_stall
  );

  modport slave (
    input  cpu_addr, cpu_data_out, cpu_write_en, cpu_read_en,
    output cpu_data_in, cpu_stall
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: decodes CPU bus accesses onto work RAM, PPU registers,
// controller ports and cartridge PRG; read data returns one cycle later.
// PPU/PRG side strobes and addresses are combinational from the current bus
// cycle, so the PPU and cartridge see an access in the same cycle as the CPU
// and their combinational read data is captured at the closing edge.
// Build option: define OAM_DMA_EN to build the $4014 OAM DMA engine.
//
// DMA state | meaning
// IDLE      | CPU owns the bus
// ALIGN     | one dead cycle after the $4014 write
// RD        | read byte {page, idx} into dma_byte, no side effects
// WR        | write dma_byte to PPU register 4 (OAMDATA), advance idx
module cpu_bus_responder #(
  parameter int RAM_ADDR_W = 11,
  parameter int PRG_ADDR_W = 15,
  parameter int DMA_LEN    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_bus_responder_if.slave    bus,
  output logic [2:0]            ppu_reg_addr,
  output logic [7:0]            ppu_reg_wdata,
  output logic                  ppu_reg_we,
  output logic                  ppu_reg_re,
  input  logic [7:0]            ppu_reg_rdata,
  output logic [PRG_ADDR_W-1:0] prg_addr,
  input  logic [7:0]            prg_rdata,
  output logic                  prg_we,
  input  logic [7:0]            pad1_buttons,
  input  logic [7:0]            pad2_buttons
);

  localparam logic [15:0] ADDR_DMA  = 16'h4014;
  localparam logic [15:0] ADDR_PAD1 = 16'h4016;
  localparam logic [15:0] ADDR_PAD2 = 16'h4017;

  logic [7:0]  ram [2**RAM_ADDR_W];
  logic        strobe;
  logic [7:0]  shift1;
  logic [7:0]  shift2;
  logic        dma_busy;
  logic        dma_rd;
  logic        dma_wr;
  logic [15:0] dma_addr;
  logic [7:0]  dma_byte;
  logic [15:0] bus_addr;
  logic        cpu_wr;
  logic        cpu_rd;
  logic        ram_sel;
  logic        ppu_sel;
  logic        prg_sel;
  logic [7:0]  rd_data;
  logic        rd_hit;

  // CPU strobes are dead while DMA owns the bus; a write masks the read side effect.
  assign cpu_wr   = bus.cpu_write_en & ~dma_busy;
  assign cpu_rd   = bus.cpu_read_en & ~bus.cpu_write_en & ~dma_busy;
  assign bus_addr = dma_rd ? dma_addr : bus.cpu_addr;
  assign ram_sel  = (bus.cpu_addr[15:13] == 3'b000);
  assign ppu_sel  = (bus.cpu_addr[15:13] == 3'b001);
  assign prg_sel  = bus.cpu_addr[15];

  assign ppu_reg_we    = rst & ((cpu_wr & ppu_sel) | dma_wr);
  assign ppu_reg_re    = rst & cpu_rd & ppu_sel;
  assign ppu_reg_addr  = !rst ? 3'd0 : (dma_wr ? 3'd4 : bus_addr[2:0]);
  assign ppu_reg_wdata = !rst ? 8'h00 : (dma_wr ? dma_byte : bus.cpu_data_out);
  assign prg_addr      = !rst ? '0 : bus_addr[PRG_ADDR_W-1:0];
  assign prg_we        = rst & cpu_wr & prg_sel;
  assign bus.cpu_stall = dma_busy;

  // Read source select; rd_hit low means open bus (previous value held).
  always_comb begin
    rd_data = 8'h00;
    rd_hit  = 1'b0;
    if (bus_addr[15:13] == 3'b000) begin
      rd_hit  = 1'b1;
      rd_data = ram[bus_addr[RAM_ADDR_W-1:0]];
    end else if (bus_addr[15:13] == 3'b001) begin
      rd_hit  = 1'b1;
      rd_data = ppu_reg_rdata;
    end else if (bus_addr == ADDR_PAD1) begin
      rd_hit  = 1'b1;
      rd_data = {7'b0, shift1[0]};
    end else if (bus_addr == ADDR_PAD2) begin
      rd_hit  = 1'b1;
      rd_data = {7'b0, shift2[0]};
    end else if (bus_addr[15]) begin
      rd_hit  = 1'b1;
      rd_data = prg_rdata;
    end
  end

  // Work RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (cpu_wr && ram_sel) ram[bus.cpu_addr[RAM_ADDR_W-1:0]] <= bus.cpu_data_out;
  end

  // Registered CPU read data, frozen while DMA runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.cpu_data_in <= 8'h00;
    else if (!dma_busy && rd_hit) bus.cpu_data_in <= rd_data;
  end

  // Controller strobe latch and serial shift registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe <= 1'b0;
      shift1 <= 8'hFF;
      shift2 <= 8'hFF;
    end else begin
      if (cpu_wr && bus.cpu_addr == ADDR_PAD1) strobe <= bus.cpu_data_out[0];
      if (strobe) begin
        shift1 <= pad1_buttons;
        shift2 <= pad2_buttons;
      end else begin
        if (cpu_rd && bus.cpu_addr == ADDR_PAD1) shift1 <= {1'b1, shift1[7:1]};
        if (cpu_rd && bus.cpu_addr == ADDR_PAD2) shift2 <= {1'b1, shift2[7:1]};
      end
    end
  end

`ifdef OAM_DMA_EN
  typedef enum logic [1:0] {DMA_IDLE, DMA_ALIGN, DMA_RD, DMA_WR} dma_state_t;
  localparam logic [7:0] DMA_LAST = 8'(DMA_LEN - 1);

  dma_state_t dma_state;
  dma_state_t dma_state_nxt;
  logic [7:0] dma_page;
  logic [7:0] dma_idx;
  logic       dma_start;

  assign dma_start = cpu_wr & (bus.cpu_addr == ADDR_DMA);
  assign dma_addr  = {dma_page, dma_idx};

  // DMA state register; reset aborts a transfer immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dma_state <= DMA_IDLE;
    else dma_state <= dma_state_nxt;
  end

  // DMA next state and per-state bus controls.
  always_comb begin
    dma_state_nxt = dma_state;
    dma_busy      = 1'b1;
    dma_rd        = 1'b0;
    dma_wr        = 1'b0;
    case (dma_state)
      DMA_IDLE: begin
        dma_busy = 1'b0;
        if (dma_start) dma_state_nxt = DMA_ALIGN;
      end
      DMA_ALIGN: dma_state_nxt = DMA_RD;
      DMA_RD: begin
        dma_rd        = 1'b1;
        dma_state_nxt = DMA_WR;
      end
      DMA_WR: begin
        dma_wr        = 1'b1;
        dma_state_nxt = (dma_idx == DMA_LAST) ? DMA_IDLE : DMA_RD;
      end
      default: dma_state_nxt = DMA_IDLE;
    endcase
  end

  // DMA page/index and the byte carried from RD to WR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_page <= 8'h00;
      dma_idx  <= 8'h00;
      dma_byte <= 8'h00;
    end else begin
      if (dma_start) begin
        dma_page <= bus.cpu_data_out;
        dma_idx  <= 8'h00;
      end
      if (dma_rd && rd_hit) dma_byte <= rd_data;
      if (dma_wr) dma_idx <= dma_idx + 8'd1;
    end
  end
`else
  assign dma_busy = 1'b0;
  assign dma_rd   = 1'b0;
  assign dma_wr   = 1'b0;
  assign dma_addr = 16'h0000;
  assign dma_byte = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder with hand-computed expectations.
`timescale 1ns/1ps
module tb_cpu_bus_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  ppu_reg_wdata;
  logic        ppu_reg_we;
  logic        ppu_reg_re;
  logic [7:0]  ppu_reg_rdata = 8'h00;
  logic [14:0] prg_addr;
  logic [7:0]  prg_rdata = 8'h00;
  logic        prg_we;
  logic [7:0]  pad1_buttons = 8'h00;
  logic [7:0]  pad2_buttons = 8'h00;

  int n_chk = 0;
  int n_err = 0;
  int exp_pad[10] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};
  int stall_cnt;
  int we_cnt;
  int re_cnt;

  cpu_bus_responder_if bus();

  cpu_bus_responder dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .ppu_reg_addr  (ppu_reg_addr),
    .ppu_reg_wdata (ppu_reg_wdata),
    .ppu_reg_we    (ppu_reg_we),
    .ppu_reg_re    (ppu_reg_re),
    .ppu_reg_rdata (ppu_reg_rdata),
    .prg_addr      (prg_addr),
    .prg_rdata     (prg_rdata),
    .prg_we        (prg_we),
    .pad1_buttons  (pad1_buttons),
    .pad2_buttons  (pad2_buttons)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr     = a;
    bus.cpu_data_out = d;
    bus.cpu_write_en = 1'b1;
    bus.cpu_read_en  = 1'b0;
    step();
    bus.cpu_write_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic re);
    bus.cpu_addr     = a;
    bus.cpu_write_en = 1'b0;
    bus.cpu_read_en  = re;
    step();
    bus.cpu_read_en  = 1'b0;
  endtask

  initial begin
    bus.cpu_addr     = 16'h2007;
    bus.cpu_data_out = 8'h55;
    bus.cpu_write_en = 1'b1;
    bus.cpu_read_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_in", bus.cpu_data_in, 8'h00);
    chk("rst_stall", bus.cpu_stall, 1'b0);
    chk("rst_ppu_we", ppu_reg_we, 1'b0);
    chk("rst_ppu_re", ppu_reg_re, 1'b0);
    chk("rst_prg_we", prg_we, 1'b0);
    chk("rst_ppu_addr", ppu_reg_addr, 3'd0);
    chk("rst_ppu_wdata", ppu_reg_wdata, 8'h00);
    chk("rst_prg_addr", prg_addr, 15'h0000);
    bus.cpu_write_en = 1'b0;
    rst = 1'b1;
    step();

    // RAM mirroring; reads with read_en low still return data
    wr(16'h0005, 8'hA5);
    wr(16'h0006, 8'h5A);
    rd(16'h0805, 1'b0);
    chk("ram_mirror_0805", bus.cpu_data_in, 8'hA5);
    rd(16'h1805, 1'b0);
    chk("ram_mirror_1805", bus.cpu_data_in, 8'hA5);
    rd(16'h0006, 1'b1);
    chk("ram_0006", bus.cpu_data_in, 8'h5A);

    // PPU register reads
    bus.cpu_addr = 16'h2002; bus.cpu_read_en = 1'b1; ppu_reg_rdata = 8'h80;
    #1;
    chk("ppu_rd_addr_2002", ppu_reg_addr, 3'd2);
    chk("ppu_re_2002", ppu_reg_re, 1'b1);
    step();
    bus.cpu_read_en = 1'b0;
    chk("ppu_rd_data_2002", bus.cpu_data_in, 8'h80);
    #1;
    chk("ppu_re_single", ppu_reg_re, 1'b0);
    bus.cpu_addr = 16'h3FFA; bus.cpu_read_en = 1'b1; ppu_reg_rdata = 8'h13;
    #1;
    chk("ppu_rd_addr_3ffa", ppu_reg_addr, 3'd2);
    chk("ppu_re_3ffa", ppu_reg_re, 1'b1);
    step();
    bus.cpu_read_en = 1'b0;
    chk("ppu_rd_data_3ffa", bus.cpu_data_in, 8'h13);

    // PPU write, with a concurrent read strobe that must be masked
    bus.cpu_addr = 16'h2006; bus.cpu_data_out = 8'h3F;
    bus.cpu_write_en = 1'b1; bus.cpu_read_en = 1'b1;
    #1;
    chk("ppu_we", ppu_reg_we, 1'b1);
    chk("ppu_we_addr", ppu_reg_addr, 3'd6);
    chk("ppu_we_data", ppu_reg_wdata, 8'h3F);
    chk("ppu_wr_wins_re", ppu_reg_re, 1'b0);
    step();
    bus.cpu_write_en = 1'b0; bus.cpu_read_en = 1'b0;
    #1;
    chk("ppu_we_pulse", ppu_reg_we, 1'b0);

    // Controllers
    pad1_buttons = 8'b0000_1001;
    pad2_buttons = 8'h02;
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) begin
      rd(16'h4016, 1'b1);
      chk($sformatf("pad1_bit%0d", i), bus.cpu_data_in, 32'(exp_pad[i]));
    end
    rd(16'h4017, 1'b1);
    chk("pad2_bit0", bus.cpu_data_in, 8'h00);
    rd(16'h4017, 1'b1);
    chk("pad2_bit1", bus.cpu_data_in, 8'h01);

    // PRG and open bus
    bus.cpu_addr = 16'h8000; prg_rdata = 8'h4C;
    #1;
    chk("prg_addr_8000", prg_addr, 15'h0000);
    step();
    chk("prg_data", bus.cpu_data_in, 8'h4C);
    prg_rdata = 8'h11;
    rd(16'h5000, 1'b1);
    chk("open_bus_hold", bus.cpu_data_in, 8'h4C);
    bus.cpu_addr = 16'hFFFF;
    #1;
    chk("prg_addr_ffff", prg_addr, 15'h7FFF);
    bus.cpu_addr = 16'h9000; bus.cpu_data_out = 8'h07;
    bus.cpu_write_en = 1'b1; bus.cpu_read_en = 1'b1;
    #1;
    chk("prg_we", prg_we, 1'b1);
    chk("prg_we_addr", prg_addr, 15'h1000);
    chk("prg_wr_no_re", ppu_reg_re, 1'b0);
    step();
    bus.cpu_write_en = 1'b0; bus.cpu_read_en = 1'b0;
    #1;
    chk("prg_we_pulse", prg_we, 1'b0);

`ifdef OAM_DMA_EN
    for (int i = 0; i < 256; i++) wr(16'h0200 + 16'(i), 8'(i) ^ 8'h3C);
    rd(16'h0005, 1'b0);
    chk("dma_pre_data", bus.cpu_data_in, 8'hA5);
    wr(16'h4014, 8'h02);
    stall_cnt = 0; we_cnt = 0; re_cnt = 0;
    for (int k = 0; k < 700; k++) begin
      if (!bus.cpu_stall) break;
      stall_cnt++;
      if (ppu_reg_re) re_cnt++;
      if (ppu_reg_we) begin
        chk("dma_waddr", ppu_reg_addr, 3'd4);
        chk($sformatf("dma_wdata%0d", we_cnt), ppu_reg_wdata, 8'(we_cnt) ^ 8'h3C);
        we_cnt++;
      end
      if (k == 10) begin
        bus.cpu_addr = 16'h4014; bus.cpu_data_out = 8'h03; bus.cpu_write_en = 1'b1;
      end else if (k == 20) begin
        bus.cpu_write_en = 1'b0; bus.cpu_addr = 16'h2002; bus.cpu_read_en = 1'b1;
      end else if (k == 40) begin
        bus.cpu_read_en = 1'b0; bus.cpu_addr = 16'h5000;
      end
      step();
    end
    chk("dma_stall_cycles", stall_cnt, 513);
    chk("dma_we_count", we_cnt, 256);
    chk("dma_no_re", re_cnt, 0);
    chk("dma_data_in_frozen", bus.cpu_data_in, 8'hA5);

    // Reset during byte 100, then a fresh transfer starts from byte 0
    wr(16'h4014, 8'h02);
    we_cnt = 0;
    for (int k = 0; k < 700; k++) begin
      if (ppu_reg_we && we_cnt == 100) break;
      if (ppu_reg_we) we_cnt++;
      step();
    end
    chk("abort_at_byte", ppu_reg_wdata, 8'd100 ^ 8'h3C);
    #2 rst = 1'b0;
    #1;
    chk("abort_stall", bus.cpu_stall, 1'b0);
    chk("abort_ppu_we", ppu_reg_we, 1'b0);
    chk("abort_data_in", bus.cpu_data_in, 8'h00);
    step();
    rst = 1'b1;
    step();
    wr(16'h4014, 8'h02);
    stall_cnt = 0; we_cnt = 0;
    for (int k = 0; k < 700; k++) begin
      if (!bus.cpu_stall) break;
      stall_cnt++;
      if (ppu_reg_we && we_cnt == 0) chk("restart_byte0", ppu_reg_wdata, 8'h3C);
      if (ppu_reg_we) we_cnt++;
      step();
    end
    chk("restart_stall_cycles", stall_cnt, 513);
    chk("restart_we_count", we_cnt, 256);
`else
    wr(16'h4014, 8'h02);
    for (int k = 0; k < 5; k++) begin
      chk("nodma_stall", bus.cpu_stall, 1'b0);
      chk("nodma_ppu_we", ppu_reg_we, 1'b0);
      step();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Responder end of the CPU execute-stage memory bus: decodes each CPU address onto internal 2 KB work RAM, PPU registers, controller ports, OAM DMA and cartridge PRG.
- Returns read data with fixed 1-cycle latency.
- Owns read side effects (PPU register read strobes, controller shifting) and the $4014 OAM DMA engine.
- Sits between the execute FSM bus pins and the PPU/cartridge/pad inputs in the CPU top level.

Parameters:
RAM_ADDR_W, 11, work-RAM index width (2**RAM_ADDR_W bytes, mirrored through $0000-$1FFF)
PRG_ADDR_W, 15, cartridge PRG address width
DMA_LEN, 256, bytes per OAM DMA transfer

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cpu_addr  in  16  CPU bus address
cpu_data_out  in  8  CPU write data
cpu_data_in  out  8  registered read data to CPU
cpu_write_en  in  1  write strobe, one cycle
cpu_read_en  in  1  side-effect read strobe, one cycle
cpu_stall  out  1  high while DMA owns the bus; gates CPU clock-enable in top level
ppu_reg_addr  out  3  PPU register index
ppu_reg_wdata  out  8  PPU register write data
ppu_reg_we  out  1  PPU register write pulse
ppu_reg_re  out  1  PPU register read pulse (status/latch side effects)
ppu_reg_rdata  in  8  PPU register read data, combinational from ppu_reg_addr
prg_addr  out  PRG_ADDR_W  PRG address
prg_rdata  in  8  PRG read data, combinational
prg_we  out  1  PRG/mapper write pulse
pad1_buttons  in  8  pad 1 state, bit0..7 = A,B,Select,Start,Up,Down,Left,Right
pad2_buttons  in  8  pad 2 state, same order

Behaviour:
- Reset (async, rst=0): cpu_data_in=0, cpu_stall=0, ppu_reg_we=ppu_reg_re=prg_we=0, ppu_reg_addr=0, ppu_reg_wdata=0, prg_addr=0, strobe=0, both shift regs=8'hFF, DMA state=IDLE. RAM contents undefined.
- Read path: at every clk edge cpu_data_in <= source selected by cpu_addr. This applies whether or not cpu_read_en is high, so stack pulls with read_en low return data. Data is valid the cycle after the address is presented.
- Decode:
  - $0000-$1FFF: RAM[addr[RAM_ADDR_W-1:0]].
  - $2000-$3FFF: PPU reg addr[2:0].
  - $4016/$4017 read: {7'b0, shift1[0]} / {7'b0, shift2[0]}.
  - $8000-$FFFF: prg_rdata, with prg_addr=addr[PRG_ADDR_W-1:0].
  - All else: open bus; cpu_data_in holds its previous value.
- Writes (cpu_write_en):
  - RAM: write at edge.
  - PPU: ppu_reg_we pulses 1 cycle with ppu_reg_addr=addr[2:0] and ppu_reg_wdata=data.
  - $4014: DMA start.
  - $4016: strobe <= data[0].
  - $8000-$FFFF: prg_we pulses.
  - Other addresses: ignored.
- Read side effects (cpu_read_en):
  - PPU region: ppu_reg_re pulses 1 cycle.
  - $4016/$4017 with strobe=0: shift reg >> 1, filling with 1.
- While strobe=1, both shift regs reload from pad inputs every cycle.
- Read and write strobes high together: the write wins and no read side effect occurs.
- DMA FSM: IDLE -> ALIGN (1 cycle) -> RD/WR alternating for DMA_LEN bytes -> IDLE.
  - RD: internal address {page, i} is decoded as above without side effects (no ppu_reg_re, no shifting).
  - WR: ppu_reg_we=1, ppu_reg_addr=4, ppu_reg_wdata=byte read in the previous cycle.
  - Counter i is 8 bits; the transfer ends after i=DMA_LEN-1 is written.
  - cpu_stall is high from the edge after the $4014 write for exactly 1+2*DMA_LEN cycles (513).
  - CPU bus strobes are ignored during DMA.
  - A $4014 write while DMA is active is ignored.
  - Reset mid-DMA aborts the transfer: cpu_stall=0 immediately.
  - cpu_data_in is not updated during DMA.

Optional Feature:
- OAM_DMA_EN defined: DMA FSM as above.
- Not defined: $4014 writes are ignored, cpu_stall is tied 0, no DMA logic is built.

Test Plan:
- Write $0005=8'hA5, then read $0805 and $1805 -> cpu_data_in=8'hA5 one cycle after the address on both reads (mirroring).
- Read $2002 with read_en=1 and ppu_reg_rdata=8'h80 -> ppu_reg_addr=2, ppu_reg_re pulses once, cpu_data_in=8'h80 next cycle. Repeat with address $3FFA -> ppu_reg_addr=2.
- pad1_buttons=8'b0000_1001; write $4016=1 then $4016=0; 10 reads of $4016 -> data bits 1,0,0,1,0,0,0,0,1,1.
- Preload RAM $0200-$02FF with i^8'h3C; write $4014=8'h02 -> cpu_stall high 513 cycles, 256 ppu_reg_we pulses at addr 4 with data i^8'h3C in order, no ppu_reg_re.
- Assert rst at DMA byte 100 -> cpu_stall, ppu_reg_we and cpu_data_in are 0 immediately; after release the next $4014 write restarts from byte 0.
- Read $5000 after reading $8000 with prg_rdata=8'h4C -> cpu_data_in stays 8'h4C. Write $9000 -> prg_we pulse; concurrent read_en produces no side effect.
